// File: rtl/if_id_stage_pkg.sv
// Shared RV32I constants for the IF/ID register and its hazard detector.
// Opcode classification helpers are reused by the decode and hazard stages.
package if_id_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Combinational load-use detector: flags an instruction that reads the
// destination of a load still sitting in ID/EX.
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  output logic        hazard
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_match;
  logic       rs2_match;
  logic       unused_bits;

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];

  assign unused_bits = ^{instr[31:25], instr[14:7]};

  // An unused register field may carry an immediate that happens to match rd.
  assign rs1_match = uses_rs1(opcode) && (rs1 == idex_rd);
  assign rs2_match = uses_rs2(opcode) && (rs2 == idex_rd);

  assign hazard = valid && idex_memread && (idex_rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush-over-stall priority, load-use stall
// control for the PC, and saturating stall/flush event counters.
module if_id_stage #(
  parameter int              XLEN      = if_id_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(if_id_stage_pkg::NOP_INSTR),
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  instr_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  pcp4_in,
  input  logic             pcsrc,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  output logic [XLEN-1:0]  instr_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pcp4_out,
  output logic             valid_out,
  output logic             pc_write,
  output logic             bubble_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import if_id_stage_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic hazard;

  load_use_detect u_load_use_detect (
    .instr        (instr_out),
    .valid        (valid_out),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .hazard       (hazard)
  );

  // A taken branch redirects the PC even when decode is stalled.
  assign pc_write    = ~hazard | pcsrc;
  assign bubble_idex = hazard & ~pcsrc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_out <= NOP_INSTR;
      pc_out    <= '0;
      pcp4_out  <= '0;
      valid_out <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (pcsrc) begin
      instr_out <= NOP_INSTR;
      pc_out    <= '0;
      pcp4_out  <= '0;
      valid_out <= 1'b0;
      if (flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end else if (hazard) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end else begin
      instr_out <= instr_in;
      pc_out    <= pc_in;
      pcp4_out  <= pcp4_in;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: a behavioural model compared every
// cycle, plus directed vectors with literal expectations.
module tb_if_id_stage;

  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [31:0]      instr_in;
  logic [31:0]      pc_in;
  logic [31:0]      pcp4_in;
  logic             pcsrc;
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [31:0]      instr_out;
  logic [31:0]      pc_out;
  logic [31:0]      pcp4_out;
  logic             valid_out;
  logic             pc_write;
  logic             bubble_idex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks;
  int failures;

  if_id_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .pcp4_in      (pcp4_in),
    .pcsrc        (pcsrc),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pcp4_out     (pcp4_out),
    .valid_out    (valid_out),
    .pc_write     (pc_write),
    .bubble_idex  (bubble_idex),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected architectural state of the stage
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_pcp4;
  bit          m_valid;
  int          m_stalls;
  int          m_flushes;

  function automatic bit model_hazard(input logic [31:0] ins, input bit v,
                                      input bit mr, input logic [4:0] rd);
    logic [6:0] op;
    bit reads_rs1;
    bit reads_rs2;
    op = ins[6:0];
    reads_rs1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    reads_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return v && mr && (rd != 5'd0) &&
           ((reads_rs1 && ins[19:15] == rd) || (reads_rs2 && ins[24:20] == rd));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_instr <= 32'h13; m_pc <= 0; m_pcp4 <= 0; m_valid <= 0;
      m_stalls <= 0; m_flushes <= 0;
    end else if (pcsrc) begin
      m_instr <= 32'h13; m_pc <= 0; m_pcp4 <= 0; m_valid <= 0;
      m_flushes <= (m_flushes < CNT_SAT) ? m_flushes + 1 : CNT_SAT;
    end else if (model_hazard(m_instr, m_valid, idex_memread, idex_rd)) begin
      m_stalls <= (m_stalls < CNT_SAT) ? m_stalls + 1 : CNT_SAT;
    end else begin
      m_instr <= instr_in; m_pc <= pc_in; m_pcp4 <= pcp4_in; m_valid <= 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    bit hz;
    hz = model_hazard(m_instr, m_valid, idex_memread, idex_rd);
    checkOutput("instr_out", instr_out, m_instr);
    checkOutput("pc_out", pc_out, m_pc);
    checkOutput("pcp4_out", pcp4_out, m_pcp4);
    checkOutput("valid_out", 32'(valid_out), 32'(m_valid));
    checkOutput("pc_write", 32'(pc_write), 32'(!hz || pcsrc));
    checkOutput("bubble_idex", 32'(bubble_idex), 32'(hz && !pcsrc));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    checkOutput("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
  end

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic br, input logic mr, input logic [4:0] rd);
    instr_in = ins;
    pc_in = pc;
    pcp4_in = pc + 32'd4;
    pcsrc = br;
    idex_memread = mr;
    idex_rd = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    applyStimulus(32'hDEADBEEF, 32'h100, 1'b1, 1'b1, 5'd3);
    tick();
    applyStimulus(32'h002080B3, 32'h200, 1'b0, 1'b1, 5'd1);
    tick();
    checkOutput("rst_instr", instr_out, 32'h13);
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_valid", 32'(valid_out), 32'h0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    checkOutput("rst_pc_write", 32'(pc_write), 32'h1);

    #2 rst = 1'b1;
    applyStimulus(32'h00500093, 32'h40, 1'b0, 1'b0, 5'd0);
    tick();
    checkOutput("first_instr", instr_out, 32'h00500093);
    checkOutput("first_pc", pc_out, 32'h40);
    checkOutput("first_pcp4", pcp4_out, 32'h44);
    checkOutput("first_valid", 32'(valid_out), 32'h1);

    // Load-use: add x1,x1,x2 behind a load of x2
    applyStimulus(32'h002080B3, 32'h44, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h00310133, 32'h48, 1'b0, 1'b1, 5'd2);
    checkOutput("lu_pc_write", 32'(pc_write), 32'h0);
    checkOutput("lu_bubble", 32'(bubble_idex), 32'h1);
    tick();
    checkOutput("lu_hold_instr", instr_out, 32'h002080B3);
    checkOutput("lu_hold_pc", pc_out, 32'h44);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    applyStimulus(32'h00310133, 32'h48, 1'b0, 1'b0, 5'd0);
    checkOutput("lu_cleared", 32'(pc_write), 32'h1);
    tick();
    checkOutput("lu_resume", instr_out, 32'h00310133);

    // No false hazards: rd of x0, then LUI whose rs1 field holds 2
    applyStimulus(32'h000120B7, 32'h4C, 1'b0, 1'b1, 5'd0);
    checkOutput("x0_pc_write", 32'(pc_write), 32'h1);
    tick();
    applyStimulus(32'h00A00113, 32'h50, 1'b0, 1'b1, 5'd2);
    checkOutput("lui_pc_write", 32'(pc_write), 32'h1);
    tick();
    checkOutput("lui_no_stall", 32'(stall_cnt), 32'h1);
    checkOutput("lui_loaded", instr_out, 32'h00A00113);

    // Flush, then flush racing a hazard
    applyStimulus(32'h12345678, 32'h54, 1'b1, 1'b0, 5'd0);
    tick();
    checkOutput("flush_instr", instr_out, 32'h13);
    checkOutput("flush_valid", 32'(valid_out), 32'h0);
    checkOutput("flush_cnt1", 32'(flush_cnt), 32'h1);
    applyStimulus(32'h002080B3, 32'h58, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h00310133, 32'h5C, 1'b1, 1'b1, 5'd2);
    checkOutput("fh_pc_write", 32'(pc_write), 32'h1);
    checkOutput("fh_bubble", 32'(bubble_idex), 32'h0);
    tick();
    checkOutput("fh_flush_cnt", 32'(flush_cnt), 32'h2);
    checkOutput("fh_stall_cnt", 32'(stall_cnt), 32'h1);

    // Asynchronous reset in the middle of a stall
    applyStimulus(32'h002080B3, 32'h60, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h00310133, 32'h64, 1'b0, 1'b1, 5'd1);
    tick();
    #1 rst = 1'b0;
    #1;
    checkOutput("async_instr", instr_out, 32'h13);
    checkOutput("async_valid", 32'(valid_out), 32'h0);
    checkOutput("async_stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("async_pc_write", 32'(pc_write), 32'h1);
    #1 rst = 1'b1;
    tick();
    checkOutput("post_rst_load", instr_out, 32'h00310133);

    // Saturation: the held instruction keeps the hazard alive
    applyStimulus(32'h002080B3, 32'h68, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h00310133, 32'h6C, 1'b0, 1'b1, 5'd2);
    repeat (20) tick();
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    checkOutput("sat_hold_instr", instr_out, 32'h002080B3);
    applyStimulus(32'h00310133, 32'h6C, 1'b0, 1'b0, 5'd0);
    tick();
    checkOutput("sat_resume", pc_out, 32'h6C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
